// File: rtl/can_access_arbiter.sv
// Round-robin arbiter sharing one CAN register port between requesters A and B.
// Optional ownership locking with timeout is compiled in with `define CAN_ARB_LOCK_EN.
`timescale 1ns/1ps
module can_access_arbiter #(
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned LOCK_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       a_lock,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    input  logic       b_lock,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic [7:0] can_addr,
    output logic [7:0] can_wdata,
    output logic       can_wr_en,
    output logic       can_rd_en,
    input  logic [7:0] can_rdata,
    output logic [1:0] owner,
    output logic       lock_timeout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_t;

    state_t     state_q, state_d;
    logic       side_q, side_d;    // 0 = A, 1 = B
    logic       last_q, last_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;
    logic       elig_a, elig_b, pick_b;

`ifdef CAN_ARB_LOCK_EN
    logic        locked_q, locked_d;
    logic [15:0] timer_q, timer_d;
    logic        lock_to_q, lock_to_d;
    logic        own_lock, own_req;
`endif

    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        elig_a    = a_req;
        elig_b    = b_req;
        pick_b    = 1'b0;
`ifdef CAN_ARB_LOCK_EN
        locked_d  = locked_q;
        timer_d   = timer_q;
        lock_to_d = lock_to_q;
        own_lock  = side_q ? b_lock : a_lock;
        own_req   = side_q ? b_req : a_req;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef CAN_ARB_LOCK_EN
                if (locked_q) begin
                    if (!own_lock) begin
                        locked_d = 1'b0;
                        timer_d  = '0;
                    end else if (own_req) begin
                        elig_a  = ~side_q & a_req;
                        elig_b  = side_q & b_req;
                        timer_d = '0;
                    end else if (timer_q >= 16'(LOCK_TIMEOUT - 1)) begin
                        // Forced release; owner req is low, so the other side wins now
                        locked_d  = 1'b0;
                        timer_d   = '0;
                        lock_to_d = 1'b1;
                    end else begin
                        elig_a  = 1'b0;
                        elig_b  = 1'b0;
                        timer_d = timer_q + 16'd1;
                    end
                end
`endif
                pick_b = elig_b & (~elig_a | ~last_q);
                if (elig_a | elig_b) begin
                    side_d  = pick_b;
                    we_d    = pick_b ? b_we : a_we;
                    addr_d  = pick_b ? b_addr : a_addr;
                    wdata_d = pick_b ? b_wdata : a_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = we_q ? StAck : StWait;
            end
            StWait: begin
                if (cnt_q == 3'(RD_LAT - 1)) begin
                    if (side_q) b_rdata_d = can_rdata;
                    else        a_rdata_d = can_rdata;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StAck: begin
                last_d  = side_q;
                state_d = StIdle;
`ifdef CAN_ARB_LOCK_EN
                locked_d = own_lock;
                timer_d  = '0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            side_q    <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            side_q    <= side_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

`ifdef CAN_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q  <= 1'b0;
            timer_q   <= '0;
            lock_to_q <= 1'b0;
        end else begin
            locked_q  <= locked_d;
            timer_q   <= timer_d;
            lock_to_q <= lock_to_d;
        end
    end

    assign lock_timeout = lock_to_q;
`else
    logic unused_lock;
    localparam int unsigned unused_lock_timeout = LOCK_TIMEOUT;
    assign unused_lock  = a_lock ^ b_lock;
    assign lock_timeout = 1'b0;
`endif

    always_comb begin
        owner     = (state_q == StIdle) ? 2'b00 : (side_q ? 2'b10 : 2'b01);
        can_wr_en = (state_q == StIssue) & we_q;
        can_rd_en = (state_q == StIssue) & ~we_q;
        a_ack     = (state_q == StAck) & ~side_q;
        b_ack     = (state_q == StAck) & side_q;
        can_addr  = addr_q;
        can_wdata = wdata_q;
        a_rdata   = a_rdata_q;
        b_rdata   = b_rdata_q;
    end

endmodule
